ppu_vram_port: RTL and testbench

//  CPU-side access port into PPU memory space ($2006 PPUADDR / $2007 PPUDATA).

---
 rtl/ppu_vram_port.sv | 134 +++++++++++++
 tb/tb_ppu_vram_port.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_vram_port.sv
// CPU-side PPUADDR/PPUDATA port: write toggle, temp/current VRAM address and read buffer.
// Issues single-cycle read/write transactions to a synchronous VRAM with VRAM_RD_LAT read latency.
module ppu_vram_port #(
  parameter int VRAM_RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_sel,
  input  logic [2:0]  cpu_reg,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_din,
  input  logic        inc32,
  output logic [7:0]  cpu_dout,
  output logic        cpu_rvalid,
  output logic        busy,
  output logic [15:0] vram_addr,
  output logic        vram_WE,
  output logic [7:0]  vram_din,
  input  logic [7:0]  vram_dout
);

  typedef enum logic [2:0] {IDLE, WR, RD_WAIT, RD_CAP, PF_WAIT, PF_CAP} state_t;

  localparam int CW = 8;
  localparam logic [CW-1:0] LAST_WAIT = CW'(VRAM_RD_LAT - 1);
  localparam logic [CW-1:0] LAST_CAP  = CW'(VRAM_RD_LAT);

  state_t         state, state_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  // t[7:0] is consumed by the same $2006 write that sets it, so only the high part is held.
  logic [5:0]     t_hi;
  logic [13:0]    v;
  logic           w;
  logic [7:0]     read_buf;
  logic [7:0]     dout_q;
  logic           rd_pulse;

  logic           idle, wr_2006, wr_2007, rd_2007, rd_2002, pal;
  logic           adv_v, cap_buf, pf_valid;
  logic [13:0]    v_inc, addr_mux;

  assign idle    = (state == IDLE);
  assign wr_2006 = cpu_sel &  cpu_we & (cpu_reg == 3'd6) & idle;
  assign wr_2007 = cpu_sel &  cpu_we & (cpu_reg == 3'd7) & idle;
  assign rd_2007 = cpu_sel & ~cpu_we & (cpu_reg == 3'd7) & idle;
  assign rd_2002 = cpu_sel & ~cpu_we & (cpu_reg == 3'd2);
  assign pal     = (v >= 14'h3F00);
  assign v_inc   = v + (inc32 ? 14'd32 : 14'd1);

  always_comb begin
    state_nx = state;
    cnt_nx   = '0;
    adv_v    = 1'b0;
    cap_buf  = 1'b0;
    pf_valid = 1'b0;
    addr_mux = v;
    case (state)
      IDLE: begin
        if (wr_2007)      state_nx = WR;
        else if (rd_2007) state_nx = pal ? PF_WAIT : RD_WAIT;
      end
      WR: begin
        adv_v    = 1'b1;
        state_nx = IDLE;
      end
      RD_WAIT: begin
        if (cnt == LAST_WAIT) state_nx = RD_CAP;
        else                  cnt_nx   = cnt + CW'(1);
      end
      RD_CAP: begin
        cap_buf  = 1'b1;
        adv_v    = 1'b1;
        state_nx = IDLE;
      end
      PF_WAIT: begin
        if (cnt == LAST_WAIT) state_nx = PF_CAP;
        else                  cnt_nx   = cnt + CW'(1);
      end
      PF_CAP: begin
        // Palette data lands on the first cycle here while the nametable fetch is issued.
        addr_mux = {2'b10, v[11:0]};
        pf_valid = (cnt == '0);
        if (cnt == LAST_CAP) begin
          cap_buf  = 1'b1;
          adv_v    = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      t_hi     <= '0;
      v        <= '0;
      w        <= 1'b0;
      read_buf <= '0;
      dout_q   <= '0;
      rd_pulse <= 1'b0;
      vram_din <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      rd_pulse <= rd_2007 & ~pal;
      if (rd_2007 & ~pal) dout_q   <= read_buf;
      if (wr_2007)        vram_din <= cpu_din;
      if (cap_buf)        read_buf <= vram_dout;
      if (rd_2002) begin
        w <= 1'b0;
      end else if (wr_2006) begin
        if (!w) begin
          t_hi <= cpu_din[5:0];
          w    <= 1'b1;
        end else begin
          v <= {t_hi, cpu_din};
          w <= 1'b0;
        end
      end
      if (adv_v) v <= v_inc;
    end
  end

  assign vram_addr  = {2'b00, addr_mux};
  assign vram_WE    = (state == WR);
  assign busy       = ~idle;
  assign cpu_rvalid = rd_pulse | pf_valid;
  assign cpu_dout   = pf_valid ? vram_dout : dout_q;

endmodule

// File: tb/tb_ppu_vram_port.sv
// Bench for ppu_vram_port: directed CPU accesses, a transaction-level model feeding a
// per-cycle expectation queue, and hand-computed literal checks.
module tb_ppu_vram_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_sel;
  logic [2:0]  cpu_reg;
  logic        cpu_we;
  logic [7:0]  cpu_din;
  logic        inc32;
  logic [7:0]  cpu_dout;
  logic        cpu_rvalid;
  logic        busy;
  logic [15:0] vram_addr;
  logic        vram_WE;
  logic [7:0]  vram_din;
  logic [7:0]  vram_dout;

  ppu_vram_port #(.VRAM_RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .cpu_sel(cpu_sel), .cpu_reg(cpu_reg), .cpu_we(cpu_we),
    .cpu_din(cpu_din), .inc32(inc32), .cpu_dout(cpu_dout), .cpu_rvalid(cpu_rvalid),
    .busy(busy), .vram_addr(vram_addr), .vram_WE(vram_WE), .vram_din(vram_din),
    .vram_dout(vram_dout)
  );

  always #5 clk = ~clk;

  // Synchronous VRAM, one cycle read latency
  bit [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (vram_WE) mem[vram_addr] <= vram_din;
    vram_dout <= mem[vram_addr];
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        busy;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  din;
    logic        rv;
    logic [7:0]  dout;
  } exp_t;

  exp_t        q[$];
  bit [7:0]    mm [0:16383];
  logic [13:0] mv = '0, mt = '0;
  logic        mw = 1'b0;
  logic [7:0]  mbuf = '0;
  logic        chk_en = 1'b0;

  int          we_cnt = 0;
  logic [15:0] last_we_addr = '0;
  logic [7:0]  last_we_din = '0;
  logic [7:0]  last_rd = '0;
  int          rd_cnt = 0;

  always @(negedge clk) begin
    exp_t        e;
    logic [13:0] step, nt;
    if (q.size() > 0) e = q.pop_front();
    else e = '{busy: 1'b0, we: 1'b0, addr: {2'b00, mv}, din: 8'h00, rv: 1'b0, dout: 8'h00};

    if (chk_en) begin
      chk("busy", {31'd0, busy}, {31'd0, e.busy});
      chk("vram_WE", {31'd0, vram_WE}, {31'd0, e.we});
      chk("vram_addr", {16'd0, vram_addr}, {16'd0, e.addr});
      if (e.we) chk("vram_din", {24'd0, vram_din}, {24'd0, e.din});
      chk("cpu_rvalid", {31'd0, cpu_rvalid}, {31'd0, e.rv});
      if (e.rv) chk("cpu_dout", {24'd0, cpu_dout}, {24'd0, e.dout});
    end
    if (vram_WE) begin
      we_cnt++;
      last_we_addr = vram_addr;
      last_we_din  = vram_din;
    end
    if (cpu_rvalid) begin
      rd_cnt++;
      last_rd = cpu_dout;
    end

    step = inc32 ? 14'd32 : 14'd1;
    if (reset) begin
      q.delete();
      mv = '0; mt = '0; mw = 1'b0; mbuf = '0;
    end else if (cpu_sel) begin
      if (cpu_reg == 3'd2 && !cpu_we) begin
        mw = 1'b0;
      end else if (!e.busy && cpu_reg == 3'd6 && cpu_we) begin
        if (!mw) begin
          mt[13:8] = cpu_din[5:0];
          mw = 1'b1;
        end else begin
          mt[7:0] = cpu_din;
          mv = mt;
          mw = 1'b0;
        end
      end else if (!e.busy && cpu_reg == 3'd7 && cpu_we) begin
        q.push_back('{busy: 1'b1, we: 1'b1, addr: {2'b00, mv}, din: cpu_din, rv: 1'b0, dout: 8'h00});
        mm[mv] = cpu_din;
        mv = mv + step;
      end else if (!e.busy && cpu_reg == 3'd7 && !cpu_we) begin
        if (mv < 14'h3F00) begin
          q.push_back('{busy: 1'b1, we: 1'b0, addr: {2'b00, mv}, din: 8'h00, rv: 1'b1, dout: mbuf});
          q.push_back('{busy: 1'b1, we: 1'b0, addr: {2'b00, mv}, din: 8'h00, rv: 1'b0, dout: 8'h00});
          mbuf = mm[mv];
        end else begin
          nt = {2'b10, mv[11:0]};
          q.push_back('{busy: 1'b1, we: 1'b0, addr: {2'b00, mv}, din: 8'h00, rv: 1'b0, dout: 8'h00});
          q.push_back('{busy: 1'b1, we: 1'b0, addr: {2'b00, nt}, din: 8'h00, rv: 1'b1, dout: mm[mv]});
          q.push_back('{busy: 1'b1, we: 1'b0, addr: {2'b00, nt}, din: 8'h00, rv: 1'b0, dout: 8'h00});
          mbuf = mm[nt];
        end
        mv = mv + step;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic acc(input logic [2:0] r, input logic we, input logic [7:0] d);
    cpu_sel = 1'b1; cpu_reg = r; cpu_we = we; cpu_din = d;
    @(posedge clk); #1;
    cpu_sel = 1'b0; cpu_we = 1'b0; cpu_din = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_v(input logic [7:0] hi, input logic [7:0] lo);
    acc(3'd6, 1'b1, hi);
    acc(3'd6, 1'b1, lo);
  endtask

  task automatic pulse_reset;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    int we0, rd0;
    reset = 1'b1; cpu_sel = 1'b0; cpu_reg = 3'd0; cpu_we = 1'b0; cpu_din = 8'h00; inc32 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst cpu_dout", {24'd0, cpu_dout}, 32'h00);
    chk("rst cpu_rvalid", {31'd0, cpu_rvalid}, 32'h0);
    chk("rst busy", {31'd0, busy}, 32'h0);
    chk("rst vram_addr", {16'd0, vram_addr}, 32'h0000);
    chk("rst vram_WE", {31'd0, vram_WE}, 32'h0);
    chk("rst vram_din", {24'd0, vram_din}, 32'h00);
    chk_en = 1'b1;

    // T1: address load and single write
    set_v(8'h21, 8'h08);
    acc(3'd7, 1'b1, 8'h5A);
    idle(3);
    chk("t1 we pulses", we_cnt, 32'd1);
    chk("t1 we addr", {16'd0, last_we_addr}, 32'h2108);
    chk("t1 we din", {24'd0, last_we_din}, 32'h5A);
    chk("t1 v", {16'd0, vram_addr}, 32'h2109);
    chk("t1 model v", {18'd0, mv}, 32'h2109);

    // T2: preload then buffered reads
    set_v(8'h24, 8'h00);
    acc(3'd7, 1'b1, 8'h11); idle(2);
    acc(3'd7, 1'b1, 8'h22); idle(2);
    set_v(8'h24, 8'h00);
    acc(3'd7, 1'b0, 8'h00); idle(3);
    chk("t2 read1", {24'd0, last_rd}, 32'h00);
    acc(3'd7, 1'b0, 8'h00); idle(3);
    chk("t2 read2", {24'd0, last_rd}, 32'h11);
    chk("t2 model buf", {24'd0, mbuf}, 32'h22);
    chk("t2 v", {16'd0, vram_addr}, 32'h2402);
    acc(3'd7, 1'b0, 8'h00); idle(3);
    chk("t2 read3 buf", {24'd0, last_rd}, 32'h22);

    // T3: increment by 32 and wrap at 3FFF
    inc32 = 1'b1;
    set_v(8'h23, 8'hE0);
    acc(3'd7, 1'b1, 8'hAA); idle(2);
    chk("t3 inc32", {16'd0, vram_addr}, 32'h2400);
    inc32 = 1'b0;
    set_v(8'h3F, 8'hFF);
    acc(3'd7, 1'b1, 8'hBB); idle(2);
    chk("t3 wrap", {16'd0, vram_addr}, 32'h0000);

    // T4: palette read bypasses the buffer and refills it from the nametable below
    set_v(8'h2F, 8'h05);
    acc(3'd7, 1'b1, 8'h77); idle(2);
    set_v(8'h3F, 8'h05);
    acc(3'd7, 1'b1, 8'h0C); idle(2);
    set_v(8'h3F, 8'h05);
    rd0 = rd_cnt;
    acc(3'd7, 1'b0, 8'h00); idle(4);
    chk("t4 palette data", {24'd0, last_rd}, 32'h0C);
    chk("t4 one rvalid", rd_cnt - rd0, 32'd1);
    chk("t4 v", {16'd0, vram_addr}, 32'h3F06);
    set_v(8'h20, 8'h00);
    acc(3'd7, 1'b0, 8'h00); idle(3);
    chk("t4 buf from nt", {24'd0, last_rd}, 32'h77);

    // T5: $2002 resets the toggle between the two $2006 writes
    set_v(8'h21, 8'h00); idle(1);
    acc(3'd6, 1'b1, 8'h21);
    acc(3'd2, 1'b0, 8'h00);
    acc(3'd6, 1'b1, 8'h30); idle(1);
    chk("t5 v unchanged", {16'd0, vram_addr}, 32'h2100);
    chk("t5 model w", {31'd0, mw}, 32'h1);
    chk("t5 model t hi", {26'd0, mt[13:8]}, 32'h30);
    acc(3'd6, 1'b1, 8'h45); idle(1);
    chk("t5 v loaded", {16'd0, vram_addr}, 32'h3045);

    // accesses while busy are dropped, except $2002 clearing w
    set_v(8'h21, 8'h00);
    we0 = we_cnt;
    acc(3'd7, 1'b0, 8'h00);
    acc(3'd7, 1'b1, 8'hEE);
    acc(3'd6, 1'b1, 8'h12);
    idle(3);
    chk("busy ign we", we_cnt - we0, 32'd0);
    chk("busy ign v", {16'd0, vram_addr}, 32'h2101);
    acc(3'd6, 1'b1, 8'h22);
    acc(3'd7, 1'b0, 8'h00);
    acc(3'd2, 1'b0, 8'h00);
    idle(3);
    set_v(8'h25, 8'h00); idle(1);
    chk("busy 2002 clears w", {16'd0, vram_addr}, 32'h2500);

    // T6: reset mid-read and mid-write
    set_v(8'h21, 8'h00);
    acc(3'd7, 1'b0, 8'h00);
    pulse_reset;
    chk("t6 rd busy", {31'd0, busy}, 32'h0);
    chk("t6 rd WE", {31'd0, vram_WE}, 32'h0);
    chk("t6 rd addr", {16'd0, vram_addr}, 32'h0000);
    acc(3'd7, 1'b0, 8'h00); idle(3);
    chk("t6 buf cleared", {24'd0, last_rd}, 32'h00);
    set_v(8'h22, 8'h00);
    we0 = we_cnt;
    acc(3'd7, 1'b1, 8'h99);
    pulse_reset;
    chk("t6 wr WE", {31'd0, vram_WE}, 32'h0);
    chk("t6 wr busy", {31'd0, busy}, 32'h0);
    chk("t6 wr addr", {16'd0, vram_addr}, 32'h0000);
    chk("t6 wr one pulse", we_cnt - we0, 32'd1);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
